// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and decode-handoff bundle of the fetch unit.
// master is the fetch side; slave is the imem plus decode side.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic [7:0]      id_op;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc,
        output id_op
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc,
        input  id_op
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end: credit-limited imem requests, small instruction FIFO, redirect flush.
// FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2,
    parameter int              MAX_OUTST = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped,
`endif
    fetch_unit_if.master    bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(MAX_OUTST + BUF_DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t          fifo [BUF_DEPTH];
    entry_t          head;
    logic [PW-1:0]   wptr, rptr;
    logic [PW:0]     count;
    logic [XLEN-1:0] fetch_pc, resp_pc, target;
    logic [OW-1:0]   inflight, discard, inflight_nx;
    logic [CW-1:0]   live, credit;
    logic            req, gnt_fire, drop, push, pop, valid;

    assign target = redirect_pc & ~XLEN'(3);

    // Requests already marked for discard no longer hold a FIFO credit.
    assign live   = CW'(inflight) - CW'(discard);
    assign credit = live + CW'(count);
    assign req    = !reset && !redirect
                  && (credit < CW'(BUF_DEPTH))
                  && (inflight < OW'(MAX_OUTST));

    assign gnt_fire    = req && bus.imem_gnt;
    assign drop        = bus.imem_rvalid && (discard != '0);
    assign push        = bus.imem_rvalid && (discard == '0);
    assign valid       = !reset && (count != '0);
    assign pop         = valid && bus.id_ready;
    assign inflight_nx = inflight + OW'(gnt_fire) - OW'(bus.imem_rvalid);

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;

    assign head         = fifo[rptr];
    assign bus.id_valid = valid;
    assign bus.id_instr = valid ? head.instr : '0;
    assign bus.id_pc    = valid ? head.pc : '0;
    assign bus.id_op    = valid ? head.instr[31:24] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            inflight <= inflight_nx;
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= inflight_nx;
                wptr     <= '0;
                rptr     <= '0;
                count    <= '0;
            end else begin
                if (gnt_fire)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (drop)
                    discard <= discard - OW'(1);
                if (push) begin
                    wptr    <= wptr + PW'(1);
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (pop)
                    rptr <= rptr + PW'(1);
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !redirect && push)
            fifo[wptr] <= '{pc: resp_pc, instr: bus.imem_rdata};
    end

`ifdef FETCH_PERF_EN
    // Redirect drops whatever is buffered and not popped, plus the word returning now.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop)
                perf_fetched <= perf_fetched + 32'd1;
            if (redirect)
                perf_dropped <= perf_dropped + 32'(count) - 32'(pop)
                              + 32'(bus.imem_rvalid);
            else if (drop)
                perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

    a_rvalid_tracked: assert property (
        @(posedge clock) disable iff (reset)
        !(bus.imem_rvalid && inflight == '0)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order imem model with variable latency,
// expected fetch stream queued at grant and compared at each decode handshake.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    fetch_unit #(
        .XLEN(32),
        .RESET_PC(32'h0),
        .BUF_DEPTH(2),
        .MAX_OUTST(4)
    ) dut (
        .clock(clk),
        .reset(reset),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped),
`endif
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          pops = 0;
    bit          gnt_rand = 1'b0;
    bit          fired;
    logic [31:0] exp_fetch = 32'h0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, sample just after, advance to next negedge.
    task automatic tick(input bit rd, input logic [31:0] rpc,
                        input bit rd_if_busy, output bit did_rd);
        mreq_t       r;
        logic [31:0] e;
        logic [31:0] ed;
        logic [7:0]  eop;
        bit          rv;
        bit          gnt;
        rv = !reset && (mq.size() > 0) && (mq[0].due <= cyc);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? mdata(mq[0].addr) : 32'h0;
        gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.imem_gnt = gnt;
        redirect    = 1'b0;
        redirect_pc = rpc;
        #1;
        if (rd_if_busy)
            rd = bus.id_valid && bus.id_ready && rv;
        redirect = rd;
        did_rd   = rd;
        #1;
        if (reset) begin
            chk("rst_req", 32'(bus.imem_req), 32'h0);
            chk("rst_valid", 32'(bus.id_valid), 32'h0);
        end else begin
            chk("imem_addr", bus.imem_addr, exp_fetch);
            if (rd)
                chk("redir_req", 32'(bus.imem_req), 32'h0);
            if (bus.id_valid) begin
                if (sb.size() == 0) begin
                    chk("stale_valid", 32'(bus.id_valid), 32'h0);
                end else begin
                    e   = sb[0];
                    ed  = mdata(e);
                    eop = ed[31:24];
                    chk("id_pc", bus.id_pc, e);
                    chk("id_instr", bus.id_instr, ed);
                    chk("id_op", 32'(bus.id_op), 32'(eop));
                    if (bus.id_ready) begin
                        void'(sb.pop_front());
                        pops++;
                    end
                end
            end
            if (bus.imem_req && gnt) begin
                r.addr = exp_fetch;
                r.due  = cyc + lat;
                mq.push_back(r);
                sb.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (rv)
                void'(mq.pop_front());
            if (rd) begin
                sb.delete();
                exp_fetch = rpc & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        cyc++;
        if (reset) begin
            mq.delete();
            sb.delete();
            exp_fetch = 32'h0;
            pops = 0;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        bit f;
        for (int i = 0; i < n; i++)
            tick(1'b0, 32'h0, 1'b0, f);
    endtask

    task automatic redir(input logic [31:0] pc);
        bit f;
        tick(1'b1, pc, 1'b0, f);
    endtask

    task automatic do_reset();
        bit f;
        reset = 1'b1;
        tick(1'b0, 32'h0, 1'b0, f);
        reset = 1'b0;
    endtask

    task automatic idle_checks(input string tag);
        bus.imem_rvalid = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(bus.id_valid), 32'h0);
        chk({tag, "_instr"}, bus.id_instr, 32'h0);
        chk({tag, "_pc"}, bus.id_pc, 32'h0);
        chk({tag, "_op"}, 32'(bus.id_op), 32'h0);
        chk({tag, "_addr"}, bus.imem_addr, 32'h0);
    endtask

    initial begin
        reset           = 1'b1;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.id_ready    = 1'b1;
        @(negedge clk);
        do_reset();
        idle_checks("post_rst");

        run(20);

        do_reset();
        bus.id_ready = 1'b0;
        run(10);
        #1;
        chk("bp_req", 32'(bus.imem_req), 32'h0);
        chk("bp_valid", 32'(bus.id_valid), 32'h1);
        chk("bp_buffered", 32'(sb.size()), 32'h2);
        chk("bp_head", bus.id_pc, 32'h0);
        bus.id_ready = 1'b1;
        run(10);

        gnt_rand = 1'b1;
        run(40);
        gnt_rand = 1'b0;

        lat = 3;
        run(8);
        redir(32'h100);
        run(25);

        redir(32'h200);
        redir(32'h300);
        run(20);

        lat = 1;
        run(6);
        fired = 1'b0;
        for (int i = 0; i < 20; i++)
            if (!fired)
                tick(1'b0, 32'h400, 1'b1, fired);
        chk("coinc_fired", 32'(fired), 32'h1);
        #1;
        chk("coinc_empty", 32'(bus.id_valid), 32'h0);
        run(10);

        redir(32'hFFFF_FFFD);
        #1;
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        run(12);

        lat = 3;
        bus.id_ready = 1'b0;
        run(6);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'(pops));
`endif
        do_reset();
        bus.id_ready = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.id_valid), 32'h0);
        chk("midrst_addr", bus.imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        chk("midrst_pf", perf_fetched, 32'h0);
        chk("midrst_pd", perf_dropped, 32'h0);
`endif
        run(15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
